// File: rtl/aes_pkg.sv
// Shared AES definitions for the folded substitution engine.
//   byte_t / state_t : byte and 16-byte state types
//   SBOX / INV_SBOX  : FIPS-197 forward and inverse substitution tables
//   subs_st_e        : control states of the folded engine
package aes_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [15:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } subs_st_e;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane: substitutes a single byte.
//   in  : byte to substitute
//   inv : 1 selects the inverse table (only when INV_EN != 0)
//   out : substituted byte
module aes_sbox_lane
  import aes_pkg::*;
#(
  parameter int INV_EN = 1
) (
  input  byte_t in,
  input  logic  inv,
  output byte_t out
);

  if (INV_EN != 0) begin : g_inv
    assign out = inv ? INV_SBOX[in] : SBOX[in];
  end else begin : g_fwd
    // Forward-only build: the inverse table is never generated.
    logic unused_inv;
    assign unused_inv = inv;
    assign out        = SBOX[in];
  end

endmodule

// File: rtl/mod_subs_fold.sv
// Folded SubBytes / InvSubBytes engine. A state accepted on load/ready is
// substituted LANES bytes per cycle (ascending byte groups) through shared
// S-box lanes, then held on out_valid until out_ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   load, ready: input handshake; p and inv are captured when both are high
//   p          : input state, byte i = p[i]
//   inv        : 1 = InvSubBytes (ignored when INV_EN = 0)
//   o          : work register; a complete result only while out_valid
//   out_valid, out_ready : output handshake
//   busy       : high while groups are being substituted
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and o stays stable while
// out_valid is high and out_ready is low. In DONE, ready follows out_ready
// so a drain and a new accept can share one edge.
module mod_subs_fold
  import aes_pkg::*;
#(
  parameter int NB_BYTES = 16,
  parameter int LANES    = 4,
  parameter int INV_EN   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     inv,
  input  logic [NB_BYTES-1:0][7:0] p,
  output logic                     ready,
  output logic [NB_BYTES-1:0][7:0] o,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int N  = NB_BYTES / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  subs_st_e                  state;
  logic [CW-1:0]             cnt;
  logic [NB_BYTES-1:0][7:0]  work;
  logic                      inv_q;
  logic [LANES-1:0][7:0]     lane_in;
  logic [LANES-1:0][7:0]     lane_out;

  // Select the group addressed by cnt with constant indices only.
  always_comb begin
    lane_in = '0;
    for (int g = 0; g < N; g++) begin
      if (cnt == CW'(g)) begin
        for (int l = 0; l < LANES; l++) begin
          lane_in[l] = work[g*LANES + l];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox_lane #(.INV_EN(INV_EN)) u_lane (
      .in  (lane_in[l]),
      .inv (inv_q),
      .out (lane_out[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
      inv_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            work  <= p;
            inv_q <= inv;
            cnt   <= '0;
            state <= PROC;
          end
        end
        PROC: begin
          // Write the substituted group back in place.
          for (int g = 0; g < N; g++) begin
            if (cnt == CW'(g)) begin
              for (int l = 0; l < LANES; l++) begin
                work[g*LANES + l] <= lane_out[l];
              end
            end
          end
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (load) begin
              work  <= p;
              inv_q <= inv;
              cnt   <= '0;
              state <= PROC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o         = work;
  assign out_valid = (state == DONE);
  assign busy      = (state == PROC);
  assign ready     = (state == IDLE) || ((state == DONE) && out_ready);

endmodule

// File: tb/tb_mod_subs_fold.sv
// Self-checking bench for mod_subs_fold: three instances
// (LANES=4 with inverse, LANES=1 and LANES=16 forward-only) checked against
// a reference S-box derived from GF(2^8) arithmetic.
module tb_mod_subs_fold;

  typedef logic [15:0][7:0] st_t;

  logic clk;
  logic rst_n;
  logic load_v      [3];
  logic inv_v       [3];
  st_t  p_v         [3];
  logic ready_v     [3];
  st_t  o_v         [3];
  logic ov_v        [3];
  logic out_ready_v [3];
  logic busy_v      [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  mod_subs_fold #(.NB_BYTES(16), .LANES(4), .INV_EN(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .load(load_v[0]), .inv(inv_v[0]), .p(p_v[0]),
    .ready(ready_v[0]), .o(o_v[0]), .out_valid(ov_v[0]),
    .out_ready(out_ready_v[0]), .busy(busy_v[0]));

  mod_subs_fold #(.NB_BYTES(16), .LANES(1), .INV_EN(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load(load_v[1]), .inv(inv_v[1]), .p(p_v[1]),
    .ready(ready_v[1]), .o(o_v[1]), .out_valid(ov_v[1]),
    .out_ready(out_ready_v[1]), .busy(busy_v[1]));

  mod_subs_fold #(.NB_BYTES(16), .LANES(16), .INV_EN(0)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .load(load_v[2]), .inv(inv_v[2]), .p(p_v[2]),
    .ready(ready_v[2]), .o(o_v[2]), .out_valid(ov_v[2]),
    .out_ready(out_ready_v[2]), .busy(busy_v[2]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  task automatic build_tables();
    logic [7:0] iv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      iv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) iv = 8'(b);
      end
      s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
      fwd_tab[a] = s;
      inv_tab[s] = 8'(a);
    end
  endtask

  function automatic st_t model(input st_t s, input bit iv, input bit inv_en);
    st_t r;
    for (int i = 0; i < 16; i++) begin
      r[i] = (iv && inv_en) ? inv_tab[s[i]] : fwd_tab[s[i]];
    end
    return r;
  endfunction

  function automatic st_t rand_st();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Offer one state, then follow the engine until out_valid (bounded).
  // During processing, load/p/inv are scrambled to show they are ignored.
  task automatic run_op(input int d, input st_t pin, input bit iv, input bit drain,
                        output st_t res, output int lat, output int bsy);
    p_v[d]    = pin;
    inv_v[d]  = iv;
    load_v[d] = 1'b1;
    if (drain) out_ready_v[d] = 1'b1;
    @(posedge clk); #1;
    load_v[d]      = 1'b0;
    out_ready_v[d] = 1'b0;
    lat = 0;
    bsy = 0;
    while (ov_v[d] !== 1'b1 && lat < 100) begin
      if (busy_v[d] === 1'b1) bsy++;
      load_v[d] = 1'($urandom_range(0, 1));
      inv_v[d]  = 1'($urandom_range(0, 1));
      p_v[d]    = rand_st();
      @(posedge clk); #1;
      lat++;
    end
    load_v[d] = 1'b0;
    res = o_v[d];
  endtask

  task automatic stall(input int d, input int cycles, input st_t exp);
    for (int c = 0; c < cycles; c++) begin
      load_v[d] = 1'($urandom_range(0, 1));
      inv_v[d]  = 1'($urandom_range(0, 1));
      p_v[d]    = rand_st();
      @(posedge clk); #1;
      check("stall_o", o_v[d], exp);
      check("stall_valid", ov_v[d], 1'b1);
      check("stall_ready", ready_v[d], 1'b0);
    end
    load_v[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    out_ready_v[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[d] = 1'b0;
    check("drain_valid", ov_v[d], 1'b0);
    check("drain_ready", ready_v[d], 1'b1);
    check("drain_busy", busy_v[d], 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    st_t ident, r1, res, pin, st53, sted;
    int  lat, bsy, spurious;
    bit  iv, dr;

    for (int d = 0; d < 3; d++) begin
      load_v[d] = 1'b0; inv_v[d] = 1'b0; p_v[d] = '0; out_ready_v[d] = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      ident[i] = 8'(i);
      st53[i]  = 8'h53;
      sted[i]  = 8'hed;
    end
    build_tables();

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_ready", ready_v[d], 1'b1);
      check("rst_valid", ov_v[d], 1'b0);
      check("rst_busy", busy_v[d], 1'b0);
      check("rst_o", o_v[d], '0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Forward SubBytes of 0..15
    run_op(0, ident, 1'b0, 1'b0, r1, lat, bsy);
    check("t1_latency", lat, 4);
    check("t1_busy_cycles", bsy, 4);
    check("t1_o", r1, model(ident, 1'b0, 1'b1));
    check("t1_o0", r1[0], 8'h63);
    check("t1_o15", r1[15], 8'h76);
    drain(0);

    // Inverse round trip and 0x53 <-> 0xED spot check
    run_op(0, r1, 1'b1, 1'b0, res, lat, bsy);
    check("t2_roundtrip", res, ident);
    drain(0);
    run_op(0, st53, 1'b0, 1'b0, res, lat, bsy);
    check("t2_fwd53", res, sted);
    drain(0);
    run_op(0, sted, 1'b1, 1'b0, res, lat, bsy);
    check("t2_inved", res, st53);

    // Backpressure with ignored load pulses, then release
    stall(0, 10, st53);
    drain(0);

    // Back-to-back: drain and accept on the same edge
    pin = rand_st();
    run_op(0, pin, 1'b0, 1'b0, res, lat, bsy);
    check("t4_first", res, model(pin, 1'b0, 1'b1));
    run_op(0, '0, 1'b0, 1'b1, res, lat, bsy);
    check("t4_latency", lat, 4);
    check("t4_busy_cycles", bsy, 4);
    check("t4_o", res, {16{8'h63}});
    drain(0);

    // Reset mid-operation at cnt == 2
    p_v[0] = rand_st(); load_v[0] = 1'b1;
    @(posedge clk); #1;
    load_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t5_busy_before", busy_v[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_o", o_v[0], '0);
    check("t5_valid", ov_v[0], 1'b0);
    check("t5_ready", ready_v[0], 1'b1);
    check("t5_busy", busy_v[0], 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    spurious = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ov_v[0] !== 1'b0 || busy_v[0] !== 1'b0) spurious++;
    end
    check("t5_no_spurious", spurious, 0);

    // Random operations on the LANES=4 engine
    for (int k = 0; k < 20; k++) begin
      pin = rand_st();
      iv  = 1'($urandom_range(0, 1));
      run_op(0, pin, iv, 1'b0, res, lat, bsy);
      check("rnd_latency", lat, 4);
      check("rnd_o", res, model(pin, iv, 1'b1));
      dr = 1'($urandom_range(0, 1));
      if (dr) stall(0, $urandom_range(1, 3), res);
      drain(0);
    end

    // Forward-only builds, LANES=1 and LANES=16, inv pin driven high
    run_op(1, ident, 1'b1, 1'b0, res, lat, bsy);
    check("t6_l1_latency", lat, 16);
    check("t6_l1_busy", bsy, 16);
    check("t6_l1_o", res, model(ident, 1'b0, 1'b1));
    drain(1);
    run_op(2, ident, 1'b1, 1'b0, res, lat, bsy);
    check("t6_l16_latency", lat, 1);
    check("t6_l16_busy", bsy, 1);
    check("t6_l16_o", res, model(ident, 1'b0, 1'b1));
    drain(2);
    for (int k = 0; k < 6; k++) begin
      pin = rand_st();
      run_op(1 + (k % 2), pin, 1'($urandom_range(0, 1)), 1'b0, res, lat, bsy);
      check("t6_rnd_o", res, model(pin, 1'b1, 1'b0));
      drain(1 + (k % 2));
    end

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
